regfile_we: RTL and testbench
=============================

// Module: regfile_we
// PURPOSE
//   Parametrised multi-entry register file, successor to the single register_we.
//   DEPTH words of WIDTH bits; one synchronous write port with enable, two
//   combinational read ports.
//   Optional hardwired-zero entry 0 and optional write-to-read bypass.
//   Feeds the datapath operand fetch stage; written back from the writeback stage.
// PARAMETERS
//   WIDTH    8   data bits per entry (>=1)
//   DEPTH    8   number of entries (>=2, need not be a power of two)
//   ADDR_W   3   address width; must satisfy 2**ADDR_W >= DEPTH
//   ZERO_REG 1   1: entry 0 always reads 0 and ignores writes; 0: entry 0 is normal
//   BYPASS   1   1: a read of the address being written this cycle returns wdata
// PORTS
//   clk     in   1       rising-edge clock, sole clock
//   reset   in   1       synchronous, active-high; clears every entry
//   we      in   1       write enable, sampled at posedge clk
//   waddr   in   ADDR_W  write address
//   wdata   in   WIDTH   write data
//   raddr0  in   ADDR_W  read port 0 address
//   raddr1  in   ADDR_W  read port 1 address
//   rdata0  out  WIDTH   read port 0 data, combinational
//   rdata1  out  WIDTH   read port 1 data, combinational
//   wr_err  out  1       registered flag: previous cycle's write was dropped
// BEHAVIOUR
//   - Reset: at posedge clk with reset=1, all entries <= 0 and wr_err <= 0.
//     Reset has priority over we. After reset, rdata0/rdata1 = 0 for any address.
//   - Write: at posedge clk with reset=0, we=1, valid target -> mem[waddr] <= wdata.
//     Visible on reads from the next cycle (1-cycle write latency).
//   - Dropped write (we=1, reset=0): mem unchanged and wr_err <= 1 when
//     waddr >= DEPTH, or when ZERO_REG=1 and waddr==0.
//     Otherwise wr_err <= 0 every clock.
//   - Read: rdataN = mem[raddrN], purely combinational, zero-latency.
//     raddrN >= DEPTH reads 0.
//     ZERO_REG=1 and raddrN==0 reads 0 regardless of mem contents.
//   - Bypass (BYPASS=1): if we=1, reset=0, raddrN==waddr and the write is valid,
//     rdataN = wdata in the same cycle. Invalid/dropped writes are never bypassed.
//     Reset=1 suppresses bypass. BYPASS=0: old value until the next cycle.
//   - Both read ports may address the same entry, or the write entry, concurrently;
//     the two ports are independent.
//   - Reset asserted mid-sequence discards any write in that cycle; no partial state.
//   - All widths exact; no truncation or sign extension on data paths.
// STRUCTURE
//   - Shared package: no typedefs required. ADDR_W legality check lives in the
//     module as an elaboration-time $error.
//   - Sub-module: one register_we #(WIDTH) per entry (entries 1..DEPTH-1 when
//     ZERO_REG=1), en = we & (waddr==i) & ~reset_blocked. Shared clk/reset.
//   - Read muxes and bypass compare are local generate/always logic.
// TESTING (WIDTH=8, DEPTH=8, ZERO_REG=1, BYPASS=1 unless stated)
//   1. reset=1 one cycle, then read all addrs -> rdata0=rdata1=8'h00 everywhere.
//   2. Write 8'hA5@3 then 8'h3C@7 -> next cycle raddr0=3:A5, raddr1=7:3C, wr_err=0.
//   3. Write 8'hFF@0 -> raddr0=0 reads 00 same and next cycle; wr_err=1 next cycle.
//   4. we=1 waddr=5 wdata=8'h77, raddr0=raddr1=5 in same cycle -> both read 77
//      combinationally; with BYPASS=0 both show old value (00) until next edge.
//   5. reset=1 and we=1 waddr=2 wdata=8'h11 same cycle -> after edge raddr0=2
//      reads 00; no bypass of 11 during that cycle.
//   6. DEPTH=6, ADDR_W=3: write 8'h42@6 -> wr_err=1, raddr0=6 reads 00, entries
//      0..5 unchanged; self-checking vector file, print error count at end.

Source files
------------

// File: rtl/regfile_we_pkg.sv
// Shared constants and elaboration-time helpers for the register file slice.
package regfile_we_pkg;

   localparam int RF_WIDTH_DEF    = 8;
   localparam int RF_DEPTH_DEF    = 8;
   localparam int RF_ADDR_W_DEF   = 3;
   localparam int RF_ZERO_REG_DEF = 1;
   localparam int RF_BYPASS_DEF   = 1;

   // True when an ADDR_W-bit address can reach every one of depth entries.
   function automatic bit f_addr_w_ok(input int depth, input int addr_w);
      return (addr_w >= 1) && (addr_w < 31) && ((1 << addr_w) >= depth);
   endfunction

endpackage

// File: rtl/regfile_we_if.sv
// Write/read bus of the register file: the writeback stage writes,
// the operand fetch stage reads through two independent ports.
interface regfile_we_if
   import regfile_we_pkg::*;
#(
   parameter int WIDTH  = RF_WIDTH_DEF,
   parameter int ADDR_W = RF_ADDR_W_DEF
);
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [WIDTH-1:0]  wdata;
   logic [ADDR_W-1:0] raddr0;
   logic [ADDR_W-1:0] raddr1;
   logic [WIDTH-1:0]  rdata0;
   logic [WIDTH-1:0]  rdata1;
   logic              wr_err;

   modport master (
      output we, waddr, wdata, raddr0, raddr1,
      input  rdata0, rdata1, wr_err
   );

   modport slave (
      input  we, waddr, wdata, raddr0, raddr1,
      output rdata0, rdata1, wr_err
   );
endinterface

// File: rtl/regfile_we_register_we.sv
// Single WIDTH-bit storage register with load enable and synchronous clear.
module register_we
   import regfile_we_pkg::*;
#(
   parameter int WIDTH = RF_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   // Clear has priority over load.
   always_ff @(posedge clk) begin
      if (reset)
         r_q <= '0;
      else if (i_en)
         r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/regfile_we.sv
// DEPTH x WIDTH register file: one enabled synchronous write port, two
// combinational read ports, optional hardwired-zero entry 0 and optional
// same-cycle write-to-read bypass. wr_err flags a dropped write one cycle later.
module regfile_we
   import regfile_we_pkg::*;
#(
   parameter int WIDTH    = RF_WIDTH_DEF,
   parameter int DEPTH    = RF_DEPTH_DEF,
   parameter int ADDR_W   = RF_ADDR_W_DEF,
   parameter int ZERO_REG = RF_ZERO_REG_DEF,
   parameter int BYPASS   = RF_BYPASS_DEF
) (
   input logic          clk,
   input logic          reset,
   regfile_we_if.slave  bus
);

   if (!f_addr_w_ok(DEPTH, ADDR_W)) begin : g_bad_addr_w
      $error("regfile_we: ADDR_W=%0d cannot address DEPTH=%0d entries", ADDR_W, DEPTH);
   end
   if (WIDTH < 1 || DEPTH < 2) begin : g_bad_size
      $error("regfile_we: WIDTH must be >=1 and DEPTH >=2");
   end

   // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

   logic             w_wr_req;
   logic             w_tgt_ok;
   logic             w_wr_do;
   logic             w_wr_drop;
   logic [WIDTH-1:0] w_q [DEPTH];
   logic [WIDTH-1:0] w_rd0;
   logic [WIDTH-1:0] w_rd1;
   logic             r_wr_err;

   // A write is only attempted outside reset; it lands only on an existing,
   // writable entry, otherwise it is dropped and flagged.
   assign w_wr_req  = bus.we & ~reset;
   assign w_tgt_ok  = ({1'b0, bus.waddr} < LP_DEPTH) &&
                      !((ZERO_REG != 0) && (bus.waddr == '0));
   assign w_wr_do   = w_wr_req & w_tgt_ok;
   assign w_wr_drop = w_wr_req & ~w_tgt_ok;

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
         assign w_q[i] = '0;
      end else begin : g_reg
         register_we #(.WIDTH(WIDTH)) u_reg (
            .clk   (clk),
            .reset (reset),
            .i_en  (w_wr_do && (bus.waddr == ADDR_W'(i))),
            .i_d   (bus.wdata),
            .o_q   (w_q[i])
         );
      end
   end

   // Dropped-write flag, refreshed every clock.
   always_ff @(posedge clk) begin
      if (reset)
         r_wr_err <= 1'b0;
      else
         r_wr_err <= w_wr_drop;
   end

   // Read port 0: out-of-range addresses never match and read zero.
   always_comb begin
      w_rd0 = '0;
      for (int i = 0; i < DEPTH; i++)
         if (bus.raddr0 == ADDR_W'(i)) w_rd0 = w_q[i];
      if ((BYPASS != 0) && w_wr_do && (bus.raddr0 == bus.waddr))
         w_rd0 = bus.wdata;
   end

   // Read port 1: identical to port 0, fully independent.
   always_comb begin
      w_rd1 = '0;
      for (int i = 0; i < DEPTH; i++)
         if (bus.raddr1 == ADDR_W'(i)) w_rd1 = w_q[i];
      if ((BYPASS != 0) && w_wr_do && (bus.raddr1 == bus.waddr))
         w_rd1 = bus.wdata;
   end

   assign bus.rdata0 = w_rd0;
   assign bus.rdata1 = w_rd1;
   assign bus.wr_err = r_wr_err;

endmodule

// File: tb/tb_regfile_we.sv
// Bench for regfile_we: three configurations share one stimulus stream.
//   k=0: DEPTH=8 ZERO_REG=1 BYPASS=1 (default)
//   k=1: DEPTH=8 ZERO_REG=0 BYPASS=0
//   k=2: DEPTH=6 ZERO_REG=1 BYPASS=1
module tb_regfile_we;

   logic       clk;
   logic       reset;
   logic       we;
   logic [2:0] waddr;
   logic [7:0] wdata;
   logic [2:0] raddr0;
   logic [2:0] raddr1;

   int n_tests = 0;
   int n_fail  = 0;

   regfile_we_if #(.WIDTH(8), .ADDR_W(3)) if_a ();
   regfile_we_if #(.WIDTH(8), .ADDR_W(3)) if_b ();
   regfile_we_if #(.WIDTH(8), .ADDR_W(3)) if_c ();

   assign if_a.we = we;  assign if_a.waddr = waddr;  assign if_a.wdata = wdata;
   assign if_a.raddr0 = raddr0;  assign if_a.raddr1 = raddr1;
   assign if_b.we = we;  assign if_b.waddr = waddr;  assign if_b.wdata = wdata;
   assign if_b.raddr0 = raddr0;  assign if_b.raddr1 = raddr1;
   assign if_c.we = we;  assign if_c.waddr = waddr;  assign if_c.wdata = wdata;
   assign if_c.raddr0 = raddr0;  assign if_c.raddr1 = raddr1;

   regfile_we #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1))
      dut_a (.clk(clk), .reset(reset), .bus(if_a));
   regfile_we #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0))
      dut_b (.clk(clk), .reset(reset), .bus(if_b));
   regfile_we #(.WIDTH(8), .DEPTH(6), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1))
      dut_c (.clk(clk), .reset(reset), .bus(if_c));

   logic [7:0] d_rd0 [3];
   logic [7:0] d_rd1 [3];
   logic       d_err [3];
   assign d_rd0[0] = if_a.rdata0;  assign d_rd1[0] = if_a.rdata1;  assign d_err[0] = if_a.wr_err;
   assign d_rd0[1] = if_b.rdata0;  assign d_rd1[1] = if_b.rdata1;  assign d_err[1] = if_b.wr_err;
   assign d_rd0[2] = if_c.rdata0;  assign d_rd1[2] = if_c.rdata1;  assign d_err[2] = if_c.wr_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [7:0] m_mem [3][8];
   logic       m_err [3];

   function automatic int cfg_depth(input int k);
      return (k == 2) ? 6 : 8;
   endfunction
   function automatic bit cfg_zero(input int k);
      return k != 1;
   endfunction
   function automatic bit cfg_byp(input int k);
      return k != 1;
   endfunction

   function automatic bit tgt_ok(input int k, input int a);
      return (a < cfg_depth(k)) && !(cfg_zero(k) && a == 0);
   endfunction

   function automatic logic [7:0] exp_rd(input int k, input int a);
      if (a >= cfg_depth(k)) return 8'h00;
      if (cfg_zero(k) && a == 0) return 8'h00;
      if (cfg_byp(k) && we && !reset && a == int'(waddr) && tgt_ok(k, a)) return wdata;
      return m_mem[k][a];
   endfunction

   task automatic model_edge();
      for (int k = 0; k < 3; k++) begin
         if (reset) begin
            for (int a = 0; a < 8; a++) m_mem[k][a] = 8'h00;
            m_err[k] = 1'b0;
         end else if (we) begin
            if (tgt_ok(k, int'(waddr))) begin
               m_mem[k][waddr] = wdata;
               m_err[k] = 1'b0;
            end else begin
               m_err[k] = 1'b1;
            end
         end else begin
            m_err[k] = 1'b0;
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s cfg%0d rdata0@%0d", tag, k, raddr0), d_rd0[k], exp_rd(k, int'(raddr0)));
         chk($sformatf("%s cfg%0d rdata1@%0d", tag, k, raddr1), d_rd1[k], exp_rd(k, int'(raddr1)));
         chk($sformatf("%s cfg%0d wr_err", tag, k), {7'd0, d_err[k]}, {7'd0, m_err[k]});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic drive(input logic r, input logic w, input logic [2:0] wa,
                        input logic [7:0] wd, input logic [2:0] a0, input logic [2:0] a1);
      reset = r; we = w; waddr = wa; wdata = wd; raddr0 = a0; raddr1 = a1;
   endtask

   // ---------------- directed table (default configuration) ----------------
   typedef struct {
      logic       rst;
      logic       we;
      logic [2:0] wa;
      logic [7:0] wd;
      logic [2:0] ra0;
      logic [2:0] ra1;
      logic [7:0] e0;
      logic [7:0] e1;
      logic       eerr;
   } vec_t;

   vec_t vt [12];

   initial begin
      // Expected outputs are sampled during the row's cycle, before its edge.
      vt[0]  = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd7, 8'h00, 8'h00, 1'b0};
      vt[1]  = '{1'b0, 1'b1, 3'd3, 8'hA5, 3'd3, 3'd7, 8'hA5, 8'h00, 1'b0};
      vt[2]  = '{1'b0, 1'b1, 3'd7, 8'h3C, 3'd3, 3'd7, 8'hA5, 8'h3C, 1'b0};
      vt[3]  = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd7, 8'hA5, 8'h3C, 1'b0};
      vt[4]  = '{1'b0, 1'b1, 3'd0, 8'hFF, 3'd0, 3'd3, 8'h00, 8'hA5, 1'b0};
      vt[5]  = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd7, 8'h00, 8'h3C, 1'b1};
      vt[6]  = '{1'b0, 1'b1, 3'd5, 8'h77, 3'd5, 3'd5, 8'h77, 8'h77, 1'b0};
      vt[7]  = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd5, 3'd5, 8'h77, 8'h77, 1'b0};
      vt[8]  = '{1'b1, 1'b1, 3'd2, 8'h11, 3'd2, 3'd2, 8'h00, 8'h00, 1'b0};
      vt[9]  = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd3, 8'h00, 8'h00, 1'b0};
      vt[10] = '{1'b0, 1'b1, 3'd2, 8'h11, 3'd2, 3'd5, 8'h11, 8'h00, 1'b0};
      vt[11] = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd0, 8'h11, 8'h00, 1'b0};

      for (int k = 0; k < 3; k++) begin
         for (int a = 0; a < 8; a++) m_mem[k][a] = 8'h00;
         m_err[k] = 1'b0;
      end

      // Reset, then every address reads zero on both ports.
      drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
      tick();
      for (int a = 0; a < 8; a++) begin
         drive(1'b0, 1'b0, 3'd0, 8'h00, 3'(a), 3'(7 - a));
         #1;
         chk($sformatf("post-reset a rdata0@%0d", a), if_a.rdata0, 8'h00);
         chk($sformatf("post-reset a rdata1@%0d", 7 - a), if_a.rdata1, 8'h00);
         check_model("post-reset");
         tick();
      end

      for (int i = 0; i < 12; i++) begin
         drive(vt[i].rst, vt[i].we, vt[i].wa, vt[i].wd, vt[i].ra0, vt[i].ra1);
         #1;
         chk($sformatf("vec%0d rdata0", i), if_a.rdata0, vt[i].e0);
         chk($sformatf("vec%0d rdata1", i), if_a.rdata1, vt[i].e1);
         chk($sformatf("vec%0d wr_err", i), {7'd0, if_a.wr_err}, {7'd0, vt[i].eerr});
         check_model($sformatf("vec%0d", i));
         tick();
      end

      // No bypass without BYPASS: old value this cycle, new value next cycle.
      drive(1'b0, 1'b1, 3'd4, 8'h5A, 3'd4, 3'd4);
      #1;
      chk("nobyp same-cycle rdata0", if_b.rdata0, 8'h00);
      chk("byp same-cycle rdata1", if_a.rdata1, 8'h5A);
      tick();
      drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd4);
      #1;
      chk("nobyp next-cycle rdata0", if_b.rdata0, 8'h5A);
      tick();

      // Entry 0 is an ordinary register when ZERO_REG=0.
      drive(1'b0, 1'b1, 3'd0, 8'hC3, 3'd0, 3'd0);
      #1;
      chk("zero-reg same-cycle a", if_a.rdata0, 8'h00);
      tick();
      drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
      #1;
      chk("entry0 plain b", if_b.rdata0, 8'hC3);
      chk("entry0 zero a", if_a.rdata1, 8'h00);
      chk("entry0 flag a", {7'd0, if_a.wr_err}, 8'h01);
      chk("entry0 flag b", {7'd0, if_b.wr_err}, 8'h00);
      tick();

      // DEPTH=6: addresses 6 and 7 do not exist.
      drive(1'b0, 1'b1, 3'd6, 8'h42, 3'd6, 3'd5);
      #1;
      chk("d6 write@6 no bypass", if_c.rdata0, 8'h00);
      chk("d8 write@6 bypass", if_a.rdata0, 8'h42);
      tick();
      drive(1'b0, 1'b1, 3'd7, 8'h99, 3'd6, 3'd7);
      #1;
      chk("d6 err after @6", {7'd0, if_c.wr_err}, 8'h01);
      chk("d6 read@6", if_c.rdata0, 8'h00);
      chk("d6 read@7 bypass blocked", if_c.rdata1, 8'h00);
      chk("d8 read@6", if_a.rdata0, 8'h42);
      tick();
      for (int a = 0; a < 8; a++) begin
         drive(1'b0, 1'b0, 3'd0, 8'h00, 3'(a), 3'(a));
         #1;
         check_model($sformatf("d6-scan%0d", a));
         tick();
      end

      // Randomised traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
               3'($urandom_range(0, 7)), 8'($urandom),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
         if ($urandom_range(0, 3) == 0) raddr1 = waddr;
         if ($urandom_range(0, 3) == 0) raddr0 = waddr;
         #1;
         check_model($sformatf("rand%0d", n));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
